// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sub_pkg;

    // Default operand / result width in bits.
    localparam int DEFAULT_W = 4;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg

// File: rtl/sub_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Latency: purely combinational.
// Backpressure: none; no flow control at this level.
module sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow out when b exceeds a, or when they match and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : sub_bit

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: z = a - b mod 2^W, one bit per cycle, LSB first.
// Latency: out_valid rises W clock edges after the accepting edge; W+2 cycles minimum per operation.
// Backpressure: result held in DONE while out_ready=0; operands taken only in IDLE.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] z,
    output logic         borrow,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    // One extra bit so the counter can reach W without wrapping.
    localparam int CW = $clog2(W) + 1;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  z_sr;
    logic          br;
    logic [CW-1:0] cnt;
    logic          borrow_q;
    logic          ovf_q;
    logic          d_bit;
    logic          br_out;
    logic          last_bit;

    // The single subtractor cell always works on the current LSBs of the
    // operand shift registers and the running borrow.
    sub_bit u_bit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_out)
    );

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        last_bit   = (cnt == CW'(W - 1));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath: latch operands, shift one bit per RUN
    // cycle, and capture borrow/overflow on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            z_sr     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= {1'b0, a_sr[W-1:1]};
                    b_sr <= {1'b0, b_sr[W-1:1]};
                    z_sr <= {d_bit, z_sr[W-1:1]};
                    br   <= br_out;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        // On the last bit the shift-register LSBs hold the
                        // operand sign bits and d_bit becomes the result MSB.
                        borrow_q <= br_out;
                        ovf_q    <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
                    end
                end
                default: ;
            endcase
        end
    end

    assign z      = z_sr;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed bench for the bit-serial subtractor (W=4).
// Latency: checks W-edge result latency and W+2 back-to-back spacing.
// Backpressure: holds out_ready low to check the result is held.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] z;
    logic         borrow;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .borrow    (borrow),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present operands for one accepting edge, scramble them during RUN,
    // and wait (bounded) for out_valid. Leaves the DUT in DONE.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] zo, output logic bo,
                          output logic oo, output int lat);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            a = a + 4'd5;
            b = b ^ 4'b1011;
            @(posedge clk); #1;
            lat++;
        end
        zo = z;
        bo = borrow;
        oo = ovf;
    endtask

    // Consume the pending result with a single out_ready pulse.
    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 4'd0 ||
            borrow !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b z=%0d borrow=%b ovf=%b, want 1 0 0 0 0",
                     in_ready, out_valid, z, borrow, ovf);
        end
        // First edge after release with in_valid=0 must not start an operation.
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_accept_after_reset: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [4] = '{4'd5, 4'd3, 4'd8, 4'd7};
        logic [W-1:0] vb [4] = '{4'd3, 4'd5, 4'd1, 4'd15};
        logic [W-1:0] ez [4] = '{4'd2, 4'd14, 4'd7, 4'd8};
        logic         eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] zo;
        logic         bo;
        logic         oo;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], zo, bo, oo, lat);
            checks++;
            if (lat != W) begin
                errors++;
                $display("FAIL latency_%0d: got %0d edges, want %0d", i, lat, W);
            end
            checks++;
            if (zo !== ez[i] || bo !== eb[i] || oo !== eo[i]) begin
                errors++;
                $display("FAIL result_%0d (%0d-%0d): got z=%0d borrow=%b ovf=%b, want z=%0d borrow=%b ovf=%b",
                         i, va[i], vb[i], zo, bo, oo, ez[i], eb[i], eo[i]);
            end
            release_op();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== ez[i]) begin
                errors++;
                $display("FAIL idle_hold_%0d: got in_ready=%b out_valid=%b z=%0d, want 1 0 %0d",
                         i, in_ready, out_valid, z, ez[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] zo;
        logic         bo;
        logic         oo;
        int           lat;
        int           bad;
        run_op(4'd9, 4'd9, zo, bo, oo, lat);
        checks++;
        if (lat != W || zo !== 4'd0 || bo !== 1'b0 || oo !== 1'b0) begin
            errors++;
            $display("FAIL bp_result: got lat=%0d z=%0d borrow=%b ovf=%b, want %0d 0 0 0", lat, zo, bo, oo, W);
        end
        bad = 0;
        in_valid = 1'b1;
        a = 4'd1;
        b = 4'd2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || z !== 4'd0 || borrow !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b z=%0d borrow=%b, want 1 0 0 0",
                         i, out_valid, in_ready, z, borrow);
            end
        end
        in_valid = 1'b0;
        release_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] zo;
        logic         bo;
        logic         oo;
        int           lat;
        // Leave non-zero outputs behind so the reset has something to clear.
        run_op(4'd3, 4'd5, zo, bo, oo, lat);
        release_op();
        a = 4'd12;
        b = 4'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 4'd0 ||
            borrow !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: got in_ready=%b out_valid=%b z=%0d borrow=%b ovf=%b, want 1 0 0 0 0",
                     in_ready, out_valid, z, borrow, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(4'd6, 4'd2, zo, bo, oo, lat);
        checks++;
        if (lat != W || zo !== 4'd4 || bo !== 1'b0 || oo !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_op: got lat=%0d z=%0d borrow=%b ovf=%b, want %0d 4 0 0", lat, zo, bo, oo, W);
        end
        release_op();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa [$];
        logic [W-1:0] qb [$];
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] ez;
        logic         eborr;
        logic         eovf;
        int           last_acc;
        int           results;
        int           cyc;
        last_acc = -1;
        results = 0;
        cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        while (results < 100 && cyc < 1000) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if (in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != W + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles, want %0d", cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
                qa.push_back(a);
                qb.push_back(b);
            end
            @(posedge clk); #1;
            cyc++;
            if (out_valid === 1'b1) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got out_valid=1 with no pending operation, want none");
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    ez = ea - eb;
                    eborr = (ea < eb);
                    eovf = (ea[W-1] ^ eb[W-1]) & (ea[W-1] ^ ez[W-1]);
                    if (z !== ez || borrow !== eborr || ovf !== eovf) begin
                        errors++;
                        $display("FAIL b2b_result_%0d (%0d-%0d): got z=%0d borrow=%b ovf=%b, want z=%0d borrow=%b ovf=%b",
                                 results, ea, eb, z, borrow, ovf, ez, eborr, eovf);
                    end
                    results++;
                end
            end
        end
        checks++;
        if (results != 100) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 100", results);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor
